// File: rtl/dk_audio_i2s_tx.sv
// dk_audio_i2s_tx: 4-entry FIFO feeding a 32-bit I2S frame serializer (mono sample on both channels).
// Optional build macro DK_I2S_OFFSET_BINARY_EN serializes samples as unsigned offset binary.
`default_nettype none

module dk_audio_i2s_tx #(
  parameter int CLOCK_RATE  = 6144000,
  parameter int SAMPLE_RATE = 48000,
  parameter int BCLK_DIV    = CLOCK_RATE / (SAMPLE_RATE * 32)
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic               o_bclk,
  output logic               o_lrck,
  output logic               o_sdata,
  output logic               o_underrun,
  output logic               o_overflow
);

  localparam int            CW       = $clog2(BCLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BCLK_DIV / 2);

  generate
    if ((BCLK_DIV < 2) || ((BCLK_DIV % 2) != 0)) begin : g_bad_bclk_div
      $error("dk_audio_i2s_tx: BCLK_DIV must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;
  logic          bclk_q;

  logic [15:0]   mem_q [4];
  logic [1:0]    wptr_q, wptr_d;
  logic [1:0]    rptr_q, rptr_d;
  logic [2:0]    count_q, count_d;
  logic          full, empty, do_wr, do_pop;
  logic [15:0]   pop_data;

  logic [15:0]   hold_q;
  logic [4:0]    bit_q;
  logic          sdata_q, lrck_q, underrun_q, overflow_q;

  // Bit-timing counter runs freely whenever out of reset, in every state.
  assign wrap  = (cnt_q == CNT_LAST);
  assign cnt_d = wrap ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= (cnt_d >= CNT_HALF);
    end
  end

  assign full   = (count_q == 3'd4);
  assign empty  = (count_q == 3'd0);
  assign do_wr  = audio_clk_en && !full;
  assign do_pop = (state_q == S_LOAD) && !empty;

  always_comb begin
    wptr_d  = do_wr  ? wptr_q + 2'd1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 2'd1 : rptr_q;
    count_d = count_q;
    case ({do_wr, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wptr_q] <= in;
    end
  end

`ifdef DK_I2S_OFFSET_BINARY_EN
  assign pop_data = {~mem_q[rptr_q][15], mem_q[rptr_q][14:0]};
`else
  assign pop_data = mem_q[rptr_q];
`endif

  // Priming leaves IDLE only on a bit boundary so LOAD always sits one clk after a wrap.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q    <= S_IDLE;
      bit_q      <= '0;
      hold_q     <= '0;
      sdata_q    <= 1'b0;
      lrck_q     <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (audio_clk_en && full) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (wrap && (count_q >= 3'd2)) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (empty) begin
            underrun_q <= 1'b1;
          end else begin
            hold_q <= pop_data;
          end
          bit_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (wrap) begin
            sdata_q <= hold_q[~bit_q[3:0]];
            lrck_q  <= bit_q[4];
            bit_q   <= bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_bclk     = bclk_q;
  assign o_lrck     = lrck_q;
  assign o_sdata    = sdata_q;
  assign o_underrun = underrun_q;
  assign o_overflow = overflow_q;

endmodule

`default_nettype wire

// File: doc/dk_audio_i2s_tx.md
DK_AUDIO_I2S_TX -- requirements
Module: dk_audio_i2s_tx

Interface
REQ-001 The block SHALL have parameter CLOCK_RATE, default 6144000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter SAMPLE_RATE, default 48000, audio sample rate in Hz.
REQ-003 The block SHALL have parameter BCLK_DIV, default CLOCK_RATE/(SAMPLE_RATE*32), giving clk cycles per serial bit; it must be even and >= 2.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port I_RSTn, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port audio_clk_en, input, 1 bit, one-cycle sample strobe.
REQ-007 The block SHALL have port in, input, 16 bits signed, mono sample from a dk_* sound generator.
REQ-008 The block SHALL have port o_bclk, output, 1 bit, serial bit clock.
REQ-009 The block SHALL have port o_lrck, output, 1 bit, word select: 0 = left, 1 = right.
REQ-010 The block SHALL have port o_sdata, output, 1 bit, serial data, MSB first.
REQ-011 The block SHALL have port o_underrun, output, 1 bit, sticky flag for an empty FIFO at a frame start.
REQ-012 The block SHALL have port o_overflow, output, 1 bit, sticky flag for a write to a full FIFO.

Function
REQ-013 The block SHALL contain a 4-entry FIFO; each clk edge with audio_clk_en=1 writes in, 16-bit, wrap-around pointers, 3-bit occupancy count.
REQ-014 A write to a full FIFO SHALL be dropped, FIFO contents SHALL remain unchanged, and o_overflow SHALL be set.
REQ-015 A bit-timing counter SHALL count 0..BCLK_DIV-1; o_bclk SHALL be 0 for counts 0..BCLK_DIV/2-1 and 1 otherwise.
REQ-016 o_sdata and o_lrck SHALL change only on the clk edge where the counter wraps to 0, which is the falling edge of o_bclk.
REQ-017 A frame SHALL be 32 bits, bit index 0..31: bits 0-15 left with o_lrck=0, bits 16-31 right with o_lrck=1; left and right SHALL carry the same sample, MSB first.
REQ-018 The serializer SHALL have states IDLE, LOAD, SHIFT.
REQ-019 IDLE -> LOAD SHALL occur when occupancy >= 2 after reset; this is the initial priming.
REQ-020 LOAD SHALL last one clk: pop the FIFO into a 16-bit holding register and go to SHIFT at bit index 0.
REQ-021 If the FIFO is empty in LOAD, the block SHALL reuse the previous holding-register value and set o_underrun.
REQ-022 SHIFT SHALL advance the bit index on each counter wrap; after bit 31 it SHALL go to LOAD.
REQ-023 Bit timing SHALL continue through LOAD so that frames are contiguous.
REQ-024 A simultaneous write and pop SHALL leave occupancy unchanged; a pop of the entry being written in the same cycle is not permitted because the FIFO is non-empty in that case.
REQ-025 Left/right data SHALL lag the first written sample by priming plus one frame: at most 2 frames.

Reset
REQ-026 On I_RSTn=0 the block SHALL, asynchronously: set o_bclk=0, o_lrck=0, o_sdata=0, o_underrun=0, o_overflow=0; clear FIFO pointers and count; clear the holding register to 0; clear the bit counter; set state IDLE.
REQ-027 A reset mid-frame SHALL abort the frame immediately; after release the block SHALL re-prime from IDLE.

Configuration
REQ-028 With DK_I2S_OFFSET_BINARY_EN defined, each popped sample SHALL be converted to unsigned offset binary by adding 2**15 (MSB inverted) before serializing.
REQ-029 Without DK_I2S_OFFSET_BINARY_EN, samples SHALL be serialized as two's complement, unchanged.

Verification
REQ-030 Reset held, then released with no strobes -> o_bclk toggles every BCLK_DIV/2 clk, o_lrck=0, o_sdata=0, state remains IDLE, and both flags stay 0.
REQ-031 Write 0x1234 then 0x8001, one per sample period, with default parameters -> first frame bits 0-15 and 16-31 both equal 0x1234, next frame both equal 0x8001, and o_lrck high for exactly 16 bits per frame.
REQ-032 Stop strobes after 2 samples -> the third frame repeats the second sample and o_underrun=1 stays set until reset.
REQ-033 Five strobes in consecutive clk cycles while IDLE -> the first 4 are kept, the fifth is dropped, o_overflow=1, and serialized output is samples 1-4 in order.
REQ-034 Assert I_RSTn=0 at bit 20 of a frame -> all outputs 0 within the same cycle, then priming restarts and no corrupted partial frame appears after release.
REQ-035 With DK_I2S_OFFSET_BINARY_EN defined, input 0x0000 -> serialized 0x8000, and input 0xFFFF (-1) -> serialized 0x7FFF.
